// File: rtl/voq_sched_pkg.sv
// Shared types and default sizing for the VOQ scheduler: FSM state encoding,
// default port counts and an index-width helper that never returns zero.
package voq_sched_pkg;

    localparam int DEF_INGRESS_CNT = 4;
    localparam int DEF_EGRESS_CNT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACCEPT = 2'd2,
        ST_ISSUE  = 2'd3
    } sched_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// ptr (wrapping modulo N). Returns one-hot and binary index; both zero if idle.
module rr_arbiter
    import voq_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [N-1:0]          gnt_oh,
    output logic [idx_w(N)-1:0]   gnt_idx
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        // Walk from the farthest candidate back to ptr so the nearest winner overwrites.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_oh      = '0;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = idx_w(N)'(idx);
            end
        end
    end

endmodule

// File: rtl/islip_scheduler.sv
// Single-iteration iSLIP scheduler for a VOQ switch: snapshot requests, grant per
// egress, accept per ingress, then issue the matching for one cycle.
module islip_scheduler
    import voq_sched_pkg::*;
#(
    parameter int INGRESS_CNT = DEF_INGRESS_CNT,
    parameter int EGRESS_CNT  = DEF_EGRESS_CNT
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       sched_start,
    input  logic [INGRESS_CNT*EGRESS_CNT-1:0]          is_empty,
    input  logic [EGRESS_CNT-1:0]                      egress_ready,
    output logic                                       busy,
    output logic                                       match_valid,
    output logic [INGRESS_CNT-1:0]                     deq_en,
    output logic [INGRESS_CNT*idx_w(EGRESS_CNT)-1:0]   deq_sel,
    output logic [EGRESS_CNT-1:0]                      egress_valid,
    output logic [EGRESS_CNT*idx_w(INGRESS_CNT)-1:0]   egress_src
);

    localparam int SW = idx_w(EGRESS_CNT);
    localparam int IW = idx_w(INGRESS_CNT);

    sched_state_e                             state_q, state_d;
    logic [INGRESS_CNT-1:0][EGRESS_CNT-1:0]   req_q, req_d;
    logic [INGRESS_CNT-1:0][EGRESS_CNT-1:0]   grant_q, grant_d;
    logic [EGRESS_CNT-1:0][IW-1:0]            gsrc_q, gsrc_d;
    logic [EGRESS_CNT-1:0][IW-1:0]            gptr_q, gptr_d;
    logic [INGRESS_CNT-1:0][SW-1:0]           aptr_q, aptr_d;
    logic                                     match_valid_q, match_valid_d;
    logic [INGRESS_CNT-1:0]                   deq_en_q, deq_en_d;
    logic [INGRESS_CNT-1:0][SW-1:0]           deq_sel_q, deq_sel_d;
    logic [EGRESS_CNT-1:0]                    egress_valid_q, egress_valid_d;
    logic [EGRESS_CNT-1:0][IW-1:0]            egress_src_q, egress_src_d;

    logic [EGRESS_CNT-1:0][INGRESS_CNT-1:0]   g_oh;
    logic [EGRESS_CNT-1:0][IW-1:0]            g_idx;
    logic [INGRESS_CNT-1:0][EGRESS_CNT-1:0]   a_oh;
    logic [INGRESS_CNT-1:0][SW-1:0]           a_idx;

    for (genvar e = 0; e < EGRESS_CNT; e++) begin : g_gnt
        logic [INGRESS_CNT-1:0] col;
        for (genvar i = 0; i < INGRESS_CNT; i++) begin : g_col
            assign col[i] = req_q[i][e];
        end
        rr_arbiter #(.N(INGRESS_CNT)) u_arb (
            .req     (col),
            .ptr     (gptr_q[e]),
            .gnt_oh  (g_oh[e]),
            .gnt_idx (g_idx[e])
        );
    end

    for (genvar i = 0; i < INGRESS_CNT; i++) begin : g_acc
        rr_arbiter #(.N(EGRESS_CNT)) u_arb (
            .req     (grant_q[i]),
            .ptr     (aptr_q[i]),
            .gnt_oh  (a_oh[i]),
            .gnt_idx (a_idx[i])
        );
    end

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        grant_d        = grant_q;
        gsrc_d         = gsrc_q;
        gptr_d         = gptr_q;
        aptr_d         = aptr_q;
        match_valid_d  = 1'b0;
        deq_en_d       = '0;
        deq_sel_d      = '0;
        egress_valid_d = '0;
        egress_src_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (sched_start) begin
                    for (int i = 0; i < INGRESS_CNT; i++)
                        for (int e = 0; e < EGRESS_CNT; e++)
                            req_d[i][e] = !is_empty[i*EGRESS_CNT + e] && egress_ready[e];
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                for (int i = 0; i < INGRESS_CNT; i++)
                    for (int e = 0; e < EGRESS_CNT; e++)
                        grant_d[i][e] = g_oh[e][i];
                gsrc_d  = g_idx;
                state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                for (int i = 0; i < INGRESS_CNT; i++) begin
                    deq_en_d[i]  = |a_oh[i];
                    deq_sel_d[i] = a_idx[i];
                    for (int e = 0; e < EGRESS_CNT; e++)
                        egress_valid_d[e] = egress_valid_d[e] | a_oh[i][e];
                end
                // An accepted egress was necessarily granted to its acceptor.
                for (int e = 0; e < EGRESS_CNT; e++)
                    egress_src_d[e] = egress_valid_d[e] ? gsrc_q[e] : '0;
                match_valid_d = 1'b1;
                state_d       = ST_ISSUE;
            end
            ST_ISSUE: begin
                for (int i = 0; i < INGRESS_CNT; i++)
                    if (deq_en_q[i])
                        aptr_d[i] = SW'((int'(deq_sel_q[i]) + 1) % EGRESS_CNT);
                for (int e = 0; e < EGRESS_CNT; e++)
                    if (egress_valid_q[e])
                        gptr_d[e] = IW'((int'(egress_src_q[e]) + 1) % INGRESS_CNT);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            req_q          <= '0;
            grant_q        <= '0;
            gsrc_q         <= '0;
            gptr_q         <= '0;
            aptr_q         <= '0;
            match_valid_q  <= 1'b0;
            deq_en_q       <= '0;
            deq_sel_q      <= '0;
            egress_valid_q <= '0;
            egress_src_q   <= '0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            grant_q        <= grant_d;
            gsrc_q         <= gsrc_d;
            gptr_q         <= gptr_d;
            aptr_q         <= aptr_d;
            match_valid_q  <= match_valid_d;
            deq_en_q       <= deq_en_d;
            deq_sel_q      <= deq_sel_d;
            egress_valid_q <= egress_valid_d;
            egress_src_q   <= egress_src_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign match_valid  = match_valid_q;
    assign deq_en       = deq_en_q;
    assign deq_sel      = deq_sel_q;
    assign egress_valid = egress_valid_q;
    assign egress_src   = egress_src_q;

endmodule

// File: tb/tb_islip_scheduler.sv
// Bench for the 4x4 iSLIP scheduler: a reference iSLIP model pushes each round's
// expected matching to a queue; rounds pop and compare when match_valid fires.
module tb_islip_scheduler;

    localparam int NI = 4;
    localparam int NE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sched_start;
    logic [15:0] is_empty;
    logic [3:0]  egress_ready;
    logic        busy;
    logic        match_valid;
    logic [3:0]  deq_en;
    logic [7:0]  deq_sel;
    logic [3:0]  egress_valid;
    logic [7:0]  egress_src;

    always #5 clk = ~clk;

    islip_scheduler #(.INGRESS_CNT(NI), .EGRESS_CNT(NE)) dut (
        .clk          (clk),
        .reset        (reset),
        .sched_start  (sched_start),
        .is_empty     (is_empty),
        .egress_ready (egress_ready),
        .busy         (busy),
        .match_valid  (match_valid),
        .deq_en       (deq_en),
        .deq_sel      (deq_sel),
        .egress_valid (egress_valid),
        .egress_src   (egress_src)
    );

    typedef struct packed {
        logic [3:0] en;
        logic [7:0] sel;
        logic [3:0] ev;
        logic [7:0] src;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    int   m_gptr[NE];
    int   m_aptr[NI];

    function automatic exp_t model(input logic [15:0] emp, input logic [3:0] rdy);
        exp_t r;
        int   gsel[NE];
        int   ii, ee;
        bit   found;
        r = '0;
        for (int e = 0; e < NE; e++) begin
            gsel[e] = -1;
            for (int k = 0; k < NI; k++) begin
                ii = (m_gptr[e] + k) % NI;
                if (gsel[e] < 0 && !emp[ii*NE + e] && rdy[e]) gsel[e] = ii;
            end
        end
        for (int i = 0; i < NI; i++) begin
            found = 1'b0;
            for (int k = 0; k < NE; k++) begin
                ee = (m_aptr[i] + k) % NE;
                if (!found && gsel[ee] == i) begin
                    found           = 1'b1;
                    r.en[i]         = 1'b1;
                    r.sel[i*2 +: 2] = 2'(ee);
                    r.ev[ee]        = 1'b1;
                    r.src[ee*2 +: 2] = 2'(i);
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (r.en[i]) begin
                ee = int'(r.sel[i*2 +: 2]);
                m_aptr[i]  = (ee + 1) % NE;
                m_gptr[ee] = (i + 1) % NI;
            end
        end
        return r;
    endfunction

    // Caller must be one time unit past a clock edge with the DUT idle.
    task automatic run_round(input logic [15:0] emp, input logic [3:0] rdy, output exp_t got);
        int   waited;
        exp_t ex;
        sb.push_back(model(emp, rdy));
        is_empty     = emp;
        egress_ready = rdy;
        sched_start  = 1'b1;
        @(posedge clk); #1;
        sched_start  = 1'b0;
        is_empty     = 16'($urandom);
        egress_ready = 4'($urandom);
        nvec++;
        if (busy !== 1'b1) begin
            nerr++; $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        waited = 0;
        while (match_valid !== 1'b1 && waited < 8) begin
            nvec++;
            if (deq_en !== 4'h0 || egress_valid !== 4'h0) begin
                nerr++; $display("FAIL strobe_early: deq_en %h egress_valid %h expected 0", deq_en, egress_valid);
            end
            @(posedge clk); #1;
            waited++;
        end
        ex  = sb.pop_front();
        got = {deq_en, deq_sel, egress_valid, egress_src};
        nvec++;
        if (match_valid !== 1'b1) begin
            nerr++; $display("FAIL match_timeout: no match_valid within %0d cycles", waited);
        end else begin
            nvec++;
            if (waited !== 2) begin
                nerr++; $display("FAIL latency: got %0d extra cycles expected 2", waited);
            end
            nvec++;
            if (got.en !== ex.en) begin
                nerr++; $display("FAIL deq_en: got %h expected %h", got.en, ex.en);
            end
            nvec++;
            if (got.sel !== ex.sel) begin
                nerr++; $display("FAIL deq_sel: got %h expected %h", got.sel, ex.sel);
            end
            nvec++;
            if (got.ev !== ex.ev) begin
                nerr++; $display("FAIL egress_valid: got %h expected %h", got.ev, ex.ev);
            end
            nvec++;
            if (got.src !== ex.src) begin
                nerr++; $display("FAIL egress_src: got %h expected %h", got.src, ex.src);
            end
        end
        @(posedge clk); #1;
        nvec++;
        if (busy !== 1'b0 || match_valid !== 1'b0 || deq_en !== 4'h0 || egress_valid !== 4'h0) begin
            nerr++;
            $display("FAIL post_issue: busy %b match_valid %b deq_en %h egress_valid %h expected all 0",
                     busy, match_valid, deq_en, egress_valid);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sched_start  = 1'b1;
        is_empty     = 16'h0000;
        egress_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (busy !== 1'b0 || match_valid !== 1'b0 || deq_en !== 4'h0 || deq_sel !== 8'h00 ||
            egress_valid !== 4'h0 || egress_src !== 8'h00) begin
            nerr++;
            $display("FAIL reset_outputs: busy %b mv %b en %h sel %h ev %h src %h expected all 0",
                     busy, match_valid, deq_en, deq_sel, egress_valid, egress_src);
        end
        reset       = 1'b0;
        sched_start = 1'b0;
        for (int k = 0; k < NE; k++) m_gptr[k] = 0;
        for (int k = 0; k < NI; k++) m_aptr[k] = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        nvec++;
        if (busy !== 1'b0) begin
            nerr++; $display("FAIL reset_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_no_requests();
        exp_t got;
        do_reset();
        run_round(16'hFFFF, 4'hF, got);
        nvec++;
        if (got.en !== 4'h0 || got.ev !== 4'h0) begin
            nerr++; $display("FAIL no_req: en %h ev %h expected 0 0", got.en, got.ev);
        end
        run_round(16'h7BDE, 4'hF, got);
    endtask

    task automatic test_diagonal();
        exp_t got;
        do_reset();
        run_round(16'h7BDE, 4'hF, got);
        nvec++;
        if (got.en !== 4'hF || got.sel !== 8'hE4 || got.src !== 8'hE4) begin
            nerr++; $display("FAIL diagonal: en %h sel %h src %h expected f e4 e4", got.en, got.sel, got.src);
        end
    endtask

    task automatic test_back_to_back();
        exp_t got;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            run_round(16'hBBBB, 4'hF, got);
            nvec++;
            if (got.en !== 4'(1 << (r % 4)) || got.src[5:4] !== 2'(r % 4)) begin
                nerr++; $display("FAIL hol_round%0d: en %h src2 %0d expected %h %0d",
                                 r, got.en, got.src[5:4], 4'(1 << (r % 4)), r % 4);
            end
        end
    endtask

    task automatic test_all_request();
        exp_t got;
        do_reset();
        run_round(16'h0000, 4'hF, got);
        nvec++;
        if (got.en !== 4'h1 || got.sel !== 8'h00 || got.ev !== 4'h1 || got.src !== 8'h00) begin
            nerr++; $display("FAIL all_req_r1: en %h sel %h ev %h src %h expected 1 00 1 00",
                             got.en, got.sel, got.ev, got.src);
        end
        run_round(16'h0000, 4'hF, got);
        nvec++;
        if (got.en !== 4'h3 || got.sel !== 8'h01 || got.ev !== 4'h3 || got.src !== 8'h01) begin
            nerr++; $display("FAIL all_req_r2: en %h sel %h ev %h src %h expected 3 01 3 01",
                             got.en, got.sel, got.ev, got.src);
        end
    endtask

    task automatic test_ready_mask();
        exp_t got;
        do_reset();
        run_round(16'h7BDE, 4'hD, got);
        nvec++;
        if (got.en !== 4'hD || got.ev[1] !== 1'b0 || got.sel[3:2] !== 2'd0) begin
            nerr++; $display("FAIL ready_mask: en %h ev %h sel %h expected d, ev[1]=0, sel[1]=0",
                             got.en, got.ev, got.sel);
        end
    endtask

    task automatic test_reset_mid_round();
        exp_t got;
        do_reset();
        is_empty     = 16'h0000;
        egress_ready = 4'hF;
        sched_start  = 1'b1;
        @(posedge clk); #1;
        sched_start  = 1'b0;
        @(posedge clk); #1;
        nvec++;
        if (busy !== 1'b1) begin
            nerr++; $display("FAIL mid_busy: got %b expected 1", busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        nvec++;
        if (busy !== 1'b0 || match_valid !== 1'b0) begin
            nerr++; $display("FAIL mid_reset: busy %b match_valid %b expected 0 0", busy, match_valid);
        end
        @(posedge clk); #1;
        nvec++;
        if (match_valid !== 1'b0 || deq_en !== 4'h0) begin
            nerr++; $display("FAIL mid_no_pulse: match_valid %b deq_en %h expected 0 0", match_valid, deq_en);
        end
        run_round(16'hFFFF, 4'hF, got);
        run_round(16'h0000, 4'hF, got);
        nvec++;
        if (got.en !== 4'h1 || got.src !== 8'h00) begin
            nerr++; $display("FAIL mid_ptr_reset: en %h src %h expected 1 00", got.en, got.src);
        end
    endtask

    task automatic test_random();
        exp_t got;
        do_reset();
        repeat (24) run_round(16'($urandom), 4'($urandom) | 4'($urandom), got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        sched_start  = 1'b0;
        is_empty     = 16'hFFFF;
        egress_ready = 4'h0;
        test_reset();
        test_no_requests();
        test_diagonal();
        test_back_to_back();
        test_all_request();
        test_ready_mask();
        test_reset_mid_round();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/islip_scheduler.md
ISLIP_SCHEDULER -- requirements
Module: islip_scheduler

Interface
REQ-001 SHALL have parameter INGRESS_CNT, default 4, number of ingress ports (each with one VOQ bank).
REQ-002 SHALL have parameter EGRESS_CNT, default 4, number of egress ports (VOQs per ingress).
REQ-003 SHALL have port clk  in  1  single clock; all state on posedge clk.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port sched_start  in  1  request one scheduling round; sampled only in IDLE.
REQ-006 SHALL have port is_empty  in  INGRESS_CNT*EGRESS_CNT  bit i*EGRESS_CNT+e = VOQ e of ingress i empty.
REQ-007 SHALL have port egress_ready  in  EGRESS_CNT  egress e may take a packet this round.
REQ-008 SHALL have port busy  out  1  high in every state other than IDLE.
REQ-009 SHALL have port match_valid  out  1  one-cycle pulse, round result valid.
REQ-010 SHALL have port deq_en  out  INGRESS_CNT  per-ingress dequeue strobe, drives the VOQ unit's dequeue enable.
REQ-011 SHALL have port deq_sel  out  INGRESS_CNT*clog2(EGRESS_CNT)  per-ingress selected VOQ index.
REQ-012 SHALL have port egress_valid  out  EGRESS_CNT  egress e matched this round.
REQ-013 SHALL have port egress_src  out  EGRESS_CNT*clog2(INGRESS_CNT)  crossbar config: ingress feeding egress e.

Function
REQ-014 SHALL implement FSM IDLE -> GRANT -> ACCEPT -> ISSUE -> IDLE, one cycle per non-IDLE state.
REQ-015 In IDLE with sched_start=1 SHALL register req[i][e] = !is_empty[i*EGRESS_CNT+e] && egress_ready[e], then enter GRANT; sched_start elsewhere ignored.
REQ-016 Input changes after the snapshot SHALL NOT affect the current round.
REQ-017 GRANT: each egress e SHALL grant the first requesting ingress at or after grant_ptr[e], modulo INGRESS_CNT; grants registered.
REQ-018 ACCEPT: each ingress i SHALL accept the first granting egress at or after accept_ptr[i], modulo EGRESS_CNT; results registered into outputs.
REQ-019 ISSUE: match_valid=1; deq_en/deq_sel/egress_valid/egress_src reflect accepted pairs; all strobes zero in every other cycle.
REQ-020 Latency: sched_start in IDLE at cycle T -> match_valid at cycle T+3; minimum round period 4 cycles.
REQ-021 At ISSUE->IDLE edge, for each accepted pair (i,e): grant_ptr[e] <= (i+1) mod INGRESS_CNT, accept_ptr[i] <= (e+1) mod EGRESS_CNT; unmatched pointers SHALL hold.
REQ-022 Result SHALL be a valid matching: at most one egress per ingress, one ingress per egress.
REQ-023 No requests: round still completes, match_valid=1 with deq_en, egress_valid all zero; pointers unchanged.
REQ-024 Unmatched deq_sel/egress_src fields SHALL be 0.

Reset
REQ-025 reset SHALL force IDLE, all pointers 0, request/grant registers 0, all outputs 0, in any state including mid-round; the round in progress is discarded.
REQ-026 reset SHALL take priority over sched_start in the same cycle.

Structure
REQ-027 Shared package voq_sched_pkg SHALL hold the FSM state enum and default INGRESS_CNT/EGRESS_CNT constants.
REQ-028 SHALL instantiate sub-module rr_arbiter (N-bit request, pointer in, one-hot/index grant out, combinational) once per egress and once per ingress.

Verification
REQ-029 After reset, all is_empty=1, start -> at T+3 match_valid=1, deq_en=0000, egress_valid=0000, busy low at T+4.
REQ-030 Ingress i non-empty only at VOQ i, all ready -> deq_en=1111, deq_sel={3,2,1,0}, egress_src={3,2,1,0}.
REQ-031 All ingresses request only egress 2, four back-to-back rounds -> winners ingress 0,1,2,3 in order; grant_ptr[2] returns to 0.
REQ-032 All request all, pointers 0 -> round 1 single match 0->0; round 2 matches 0->1 and 1->0.
REQ-033 As REQ-030 but egress_ready=1101 -> ingress 1 unmatched, deq_en=1101, egress_valid[1]=0.
REQ-034 reset asserted during ACCEPT -> next cycle busy=0, no match_valid pulse, subsequent round behaves as after REQ-029 reset.
